// File: rtl/morse_msg_scheduler_if.sv
// Letter push channel: valid/ready handshake carrying a 3-bit Morse letter code.
interface morse_msg_scheduler_if;
    logic       in_valid;
    logic [2:0] in_letter;
    logic       in_ready;

    modport master (output in_valid, output in_letter, input in_ready);
    modport slave  (input in_valid, input in_letter, output in_ready);
endinterface

// File: rtl/morse_msg_scheduler.sv
// Morse letter scheduler: a small letter FIFO feeding a tick-paced 13-bit
// pattern shifter on one LED, with an LED-off gap between letters.
module morse_msg_scheduler #(
    parameter int TICK_DIV   = 25000000,
    parameter int GAP_TICKS  = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    input  logic                 abort,
    morse_msg_scheduler_if.slave push,
    output logic                 led,
    output logic                 busy,
    output logic                 letter_done,
    output logic [2:0]           fifo_count
);
    // state | meaning
    // IDLE  | LED off, waiting for a queued letter
    // LOAD  | pop FIFO head into the shifter (one cycle)
    // SHIFT | emit pattern MSB-first, one bit per tick
    // GAP   | LED off for GAP_TICKS ticks, then next letter or IDLE
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    localparam int CW = $clog2(TICK_DIV);
    localparam int GW = $clog2(GAP_TICKS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    state_t        state, state_n;
    logic [12:0]   sr, sr_n, sr_shl;
    logic          led_n;
    logic [CW-1:0] tick_cnt;
    logic [GW-1:0] gap_cnt, gap_n;
    logic          tick, pop, do_push;
    logic [2:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [2:0]    count;

    function automatic logic [12:0] pattern(input logic [2:0] code);
        pattern = '0;
        case (code)
            3'd0: pattern = 13'b1010000000000;
            3'd1: pattern = 13'b1011101110111;
            3'd2: pattern = 13'b1110111010000;
            3'd3: pattern = 13'b1011101010000;
            3'd4: pattern = 13'b1110111000000;
            3'd5: pattern = 13'b1110100000000;
            3'd6: pattern = 13'b1110111011100;
            3'd7: pattern = 13'b1011101110100;
        endcase
    endfunction

    assign push.in_ready = (count != 3'(FIFO_DEPTH));
    assign do_push       = push.in_valid & push.in_ready & ~abort;
    assign fifo_count    = count;
    assign busy          = (state != IDLE);
    assign sr_shl        = {sr[11:0], 1'b0};
    assign tick          = ((state == SHIFT) || (state == GAP)) &&
                           (tick_cnt == CW'(TICK_DIV - 1));

    // Held at zero outside SHIFT/GAP so the first tick lands TICK_DIV cycles after LOAD.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            tick_cnt <= '0;
        end else if (abort || state == IDLE || state == LOAD || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CW'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (do_push) begin
            mem[wr_ptr] <= push.in_letter;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            sr      <= '0;
            led     <= 1'b0;
            gap_cnt <= '0;
        end else begin
            state   <= state_n;
            sr      <= sr_n;
            led     <= led_n;
            gap_cnt <= gap_n;
        end
    end

    always_comb begin
        state_n     = state;
        sr_n        = sr;
        led_n       = led;
        gap_n       = gap_cnt;
        letter_done = 1'b0;
        pop         = 1'b0;
        if (abort) begin
            state_n = IDLE;
            sr_n    = '0;
            led_n   = 1'b0;
            gap_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    led_n = 1'b0;
                    if (count != 3'd0) begin
                        state_n = LOAD;
                    end
                end
                LOAD: begin
                    pop     = 1'b1;
                    sr_n    = pattern(mem[rd_ptr]);
                    gap_n   = '0;
                    state_n = SHIFT;
                end
                SHIFT: begin
                    // Leave as soon as only trailing zeros remain.
                    if (tick) begin
                        led_n = sr[12];
                        sr_n  = sr_shl;
                        if (sr_shl == 13'd0) begin
                            state_n = GAP;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        led_n = 1'b0;
                        if (gap_cnt == GW'(GAP_TICKS - 1)) begin
                            letter_done = 1'b1;
                            gap_n       = '0;
                            state_n     = (count != 3'd0) ? LOAD : IDLE;
                        end else begin
                            gap_n = gap_cnt + GW'(1);
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_morse_msg_scheduler.sv
// Bench for morse_msg_scheduler: directed and random letter streams checked
// cycle by cycle against a timeline model built from the letter patterns.
module tb_morse_msg_scheduler;
    localparam int TD  = 4;
    localparam int GAP = 3;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic       abort  = 1'b0;
    logic       led, busy, letter_done;
    logic [2:0] fifo_count;
    int         checks = 0;
    int         errors = 0;

    morse_msg_scheduler_if bus ();

    morse_msg_scheduler #(.TICK_DIV(TD), .GAP_TICKS(GAP), .FIFO_DEPTH(4)) dut (
        .CLOCK_50    (clk),
        .resetn      (resetn),
        .abort       (abort),
        .push        (bus),
        .led         (led),
        .busy        (busy),
        .letter_done (letter_done),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    logic [12:0] pat_tbl [8] = '{13'b1010000000000, 13'b1011101110111,
                                 13'b1110111010000, 13'b1011101010000,
                                 13'b1110111000000, 13'b1110100000000,
                                 13'b1110111011100, 13'b1011101110100};

    // Timeline model: a letter whose LOAD state begins at edge A puts bit k on
    // the LED at edge A+1+TD*k, clears it one tick later, and frees the
    // scheduler at edge A+1+TD*(bits+GAP).
    int          q[$];
    int          pend[$];
    bit          active, m_led, m_pushed, start;
    int          edge_n, a_edge, free_edge, cur_n, d;
    logic [12:0] cur_pat;

    function automatic int bits_of(input logic [12:0] p);
        int n = 0;
        for (int i = 0; i < 13; i++) begin
            if (p[i] && (13 - i) > n) n = 13 - i;
        end
        return n;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q.delete();
            active   = 1'b0;
            m_led    = 1'b0;
            m_pushed = 1'b0;
        end else begin
            edge_n++;
            start    = 1'b0;
            m_pushed = bus.in_valid && !abort && (q.size() < 4);
            if (abort) begin
                q.delete();
                active = 1'b0;
                m_led  = 1'b0;
            end else begin
                if (active) begin
                    if (edge_n == a_edge + 1) void'(q.pop_front());
                    d = edge_n - (a_edge + 1);
                    if (d > 0 && d % TD == 0) begin
                        if (d / TD <= cur_n) m_led = cur_pat[13 - d / TD];
                        else if (d / TD == cur_n + 1) m_led = 1'b0;
                    end
                    if (edge_n == free_edge) begin
                        active = 1'b0;
                        start  = (q.size() != 0);
                    end
                end else begin
                    start = (q.size() != 0);
                end
                if (start) begin
                    a_edge    = edge_n;
                    cur_pat   = pat_tbl[q[0]];
                    cur_n     = bits_of(cur_pat);
                    free_edge = a_edge + 1 + TD * (cur_n + GAP);
                    active    = 1'b1;
                end
                if (m_pushed) q.push_back(int'(bus.in_letter));
            end
        end
    end

    // {led, letter_done, busy, in_ready, fifo_count} expected in the current cycle
    function automatic logic [6:0] exp_vec();
        return {m_led, active && (free_edge == edge_n + 1) && !abort && resetn,
                active, q.size() < 4, 3'(q.size())};
    endfunction

    task automatic step();
        @(negedge clk);
        abort = 1'b0;
        if (m_pushed && pend.size() != 0) void'(pend.pop_front());
        bus.in_valid  = (pend.size() != 0);
        bus.in_letter = (pend.size() != 0) ? 3'(pend[0]) : 3'd0;
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        repeat (2) @(negedge clk);
        #1;
        obs = {led, letter_done, busy, bus.in_ready, fifo_count};
        checks++;
        if (obs !== 7'b0001000) begin
            errors++;
            $display("FAIL reset_state obs %b exp %b", obs, 7'b0001000);
        end
        resetn = 1'b1;
        step();
        obs = {led, letter_done, busy, bus.in_ready, fifo_count};
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_release obs %b exp %b", obs, exp_vec());
        end
    endtask

    task automatic test_single_i();
        logic [6:0] obs;
        int push_e = -1, rise_e = -1, dones = 0;
        pend.push_back(0);
        for (int c = 0; c < 200; c++) begin
            step();
            if (m_pushed && push_e < 0) push_e = edge_n;
            if (led && rise_e < 0) rise_e = edge_n;
            dones += int'(letter_done);
            obs = {led, letter_done, busy, bus.in_ready, fifo_count};
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL single_i cyc %0d obs %b exp %b", edge_n, obs, exp_vec());
            end
            if (!active && pend.size() == 0 && q.size() == 0) break;
        end
        checks++;
        if (rise_e - push_e !== 2 + TD) begin
            errors++;
            $display("FAIL single_i_latency got %0d want %0d", rise_e - push_e, 2 + TD);
        end
        checks++;
        if (dones !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_i_end dones %0d busy %b want 1 0", dones, busy);
        end
    endtask

    task automatic test_single_j();
        logic [6:0]  obs;
        logic [15:0] seq = '0;
        int          a_j = -1, nbits = 0;
        pend.push_back(1);
        for (int c = 0; c < 300; c++) begin
            step();
            if (active && a_j < 0) a_j = a_edge;
            if (a_j >= 0 && edge_n > a_j + 1 && (edge_n - a_j - 1) % TD == 0 && nbits < 16) begin
                seq = {seq[14:0], led};
                nbits++;
            end
            obs = {led, letter_done, busy, bus.in_ready, fifo_count};
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL single_j cyc %0d obs %b exp %b", edge_n, obs, exp_vec());
            end
            if (!active && pend.size() == 0 && q.size() == 0) break;
        end
        checks++;
        if (seq !== 16'b1011101110111000) begin
            errors++;
            $display("FAIL single_j_bits got %b want %b", seq, 16'b1011101110111000);
        end
    endtask

    task automatic test_fifo_full();
        logic [6:0] obs;
        int dones = 0;
        bit saw_full = 0;
        repeat (5) pend.push_back(int'($urandom_range(0, 7)));
        for (int c = 0; c < 600; c++) begin
            step();
            if (fifo_count == 3'd4 && !bus.in_ready) saw_full = 1;
            dones += int'(letter_done);
            obs = {led, letter_done, busy, bus.in_ready, fifo_count};
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL fifo_full cyc %0d obs %b exp %b", edge_n, obs, exp_vec());
            end
            if (!active && pend.size() == 0 && q.size() == 0) break;
        end
        checks++;
        if (!saw_full || dones !== 5) begin
            errors++;
            $display("FAIL fifo_full_end full %b dones %0d want 1 5", saw_full, dones);
        end
    endtask

    task automatic test_push_pop_same();
        logic [6:0] obs;
        int dones = 0;
        bit seen = 0;
        pend = '{4, 2, 3};
        for (int c = 0; c < 400; c++) begin
            step();
            if (m_pushed && active && edge_n == a_edge + 1 && !seen) begin
                seen = 1;
                checks++;
                if (fifo_count !== 3'd2) begin
                    errors++;
                    $display("FAIL push_pop_count got %0d want 2", fifo_count);
                end
            end
            dones += int'(letter_done);
            obs = {led, letter_done, busy, bus.in_ready, fifo_count};
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL push_pop cyc %0d obs %b exp %b", edge_n, obs, exp_vec());
            end
            if (!active && pend.size() == 0 && q.size() == 0) break;
        end
        checks++;
        if (!seen || dones !== 3) begin
            errors++;
            $display("FAIL push_pop_end seen %b dones %0d want 1 3", seen, dones);
        end
    endtask

    task automatic test_abort();
        logic [6:0] obs;
        int dones = 0, rises = 0, c = 0;
        logic prev = 1'b0;
        pend = '{6, 3, 2};
        while (!(active && edge_n == a_edge + 1 + 4 * TD) && c < 200) begin
            step();
            dones += int'(letter_done);
            c++;
        end
        abort         = 1'b1;
        pend.delete();
        bus.in_valid  = 1'b1;
        bus.in_letter = 3'd7;
        step();
        obs = {led, letter_done, busy, bus.in_ready, fifo_count};
        checks++;
        if (obs !== 7'b0001000 || obs !== exp_vec()) begin
            errors++;
            $display("FAIL abort_flush obs %b exp %b", obs, 7'b0001000);
        end
        pend.push_back(5);
        for (int k = 0; k < 300; k++) begin
            step();
            dones += int'(letter_done);
            if (led && !prev) rises++;
            prev = led;
            obs = {led, letter_done, busy, bus.in_ready, fifo_count};
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL abort_after cyc %0d obs %b exp %b", edge_n, obs, exp_vec());
            end
            if (!active && pend.size() == 0 && q.size() == 0) break;
        end
        checks++;
        if (dones !== 1 || rises !== 2) begin
            errors++;
            $display("FAIL abort_end dones %0d rises %0d want 1 2", dones, rises);
        end
    endtask

    task automatic test_async_reset();
        logic [6:0] obs;
        int c = 0;
        pend.push_back(0);
        while (!(active && edge_n >= a_edge + 1 + TD * (cur_n + 1)) && c < 200) begin
            step();
            c++;
        end
        pend.delete();
        #2;
        resetn = 1'b0;
        #1;
        obs = {led, letter_done, busy, bus.in_ready, fifo_count};
        checks++;
        if (obs !== 7'b0001000) begin
            errors++;
            $display("FAIL async_reset obs %b exp %b", obs, 7'b0001000);
        end
        step();
        step();
        resetn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            obs = {led, letter_done, busy, bus.in_ready, fifo_count};
            checks++;
            if (obs !== 7'b0001000 || obs !== exp_vec()) begin
                errors++;
                $display("FAIL async_idle cyc %0d obs %b exp %b", edge_n, obs, 7'b0001000);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] obs;
        for (int c = 0; c < 4000; c++) begin
            step();
            obs = {led, letter_done, busy, bus.in_ready, fifo_count};
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d obs %b exp %b", edge_n, obs, exp_vec());
            end
            if (c < 3000) begin
                if (pend.size() < 3 && $urandom_range(0, 9) == 0)
                    pend.push_back(int'($urandom_range(0, 7)));
                if ($urandom_range(0, 249) == 0) begin
                    abort = 1'b1;
                    pend.delete();
                end
            end else if (!active && pend.size() == 0 && q.size() == 0) begin
                break;
            end
        end
        checks++;
        if (busy !== 1'b0 || active) begin
            errors++;
            $display("FAIL random_drain busy %b model %b want 0 0", busy, active);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_letter = 3'd0;
        test_reset();
        test_single_i();
        test_single_j();
        test_fifo_full();
        test_push_pop_same();
        test_abort();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
